// File: rtl/predictor_pkg.sv
// ------------------------------------------------------------------
// predictor_pkg: shared types, constants and branch resolve helpers.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package predictor_pkg;

  localparam logic [2:0] COND_NONE = 3'b000;
  localparam logic [2:0] COND_JMP  = 3'b001;
  localparam logic [2:0] COND_JZ   = 3'b010;
  localparam logic [2:0] COND_JNZ  = 3'b011;
  localparam logic [2:0] COND_JC   = 3'b100;
  localparam logic [2:0] COND_JNC  = 3'b101;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic resolve_taken(input logic [2:0] cond,
                                         input logic [15:0] w,
                                         input logic cy);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_JMP: taken = 1'b1;
      COND_JZ:  taken = (w == 16'h0000);
      COND_JNZ: taken = (w != 16'h0000);
      COND_JC:  taken = cy;
      COND_JNC: taken = ~cy;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic is_branch(input logic [2:0] cond);
    return (cond >= COND_JMP) && (cond <= COND_JNC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/predictor_bht.sv
// ------------------------------------------------------------------
// predictor_bht: 2-bit counter table, async read, registered write.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module predictor_bht #(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic [1:0]            rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [1:0]            wr_data_i
);
  import predictor_pkg::*;

  logic [1:0]            mem_q [2**INDEX_BITS];
  logic                  pend_valid_q;
  logic [INDEX_BITS-1:0] pend_idx_q;
  logic [1:0]            pend_data_q;

  // Writes land one edge late; the pending slot forwards them to the read
  // port so the write data never depends combinationally on its own read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= wr_en_i;
    end
  end

  always_ff @(posedge clock) begin
    pend_idx_q  <= wr_idx_i;
    pend_data_q <= wr_data_i;
  end

  always_ff @(posedge clock) begin
    if (pend_valid_q) begin
      mem_q[pend_idx_q] <= pend_data_q;
    end
  end

  always_comb begin
    rd_data_o = mem_q[rd_idx_i];
    if (pend_valid_q && (pend_idx_q == rd_idx_i)) begin
      rd_data_o = pend_data_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_core.sv
// ------------------------------------------------------------------
// branch_predictor_core: FSM, resolve logic, outputs and statistics.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module branch_predictor_core #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [13:0]          latched_branch,
  input  logic [10:0]          latched_branch_addr,
  input  logic [15:0]          latched_W,
  input  logic                 latched_CY,
  input  logic                 latched_exec_done,
  output logic                 ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [10:0]          pred_target,
  output logic                 actual_taken,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);
  import predictor_pkg::*;

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;

  logic [2:0]            w_cond;
  logic [INDEX_BITS-1:0] w_idx;
  logic [1:0]            w_rd_data;
  logic                  w_actual;
  logic                  w_accept;
  logic                  w_wr_en;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [1:0]            w_wr_data;

  assign w_cond   = latched_branch[13:11];
  assign w_idx    = latched_branch_addr[INDEX_BITS-1:0];
  assign w_actual = resolve_taken(w_cond, latched_W, latched_CY);
  assign ready    = (state_q == ST_RUN);

  predictor_bht #(
    .INDEX_BITS (INDEX_BITS)
  ) u_bht (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_idx_i  (w_idx),
    .rd_data_o (w_rd_data),
    .wr_en_i   (w_wr_en),
    .wr_idx_i  (w_wr_idx),
    .wr_data_i (w_wr_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    w_accept  = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_idx  = w_idx;
    w_wr_data = w_rd_data;
    case (state_q)
      ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = clr_idx_q;
        w_wr_data = INIT_STATE;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (latched_exec_done && is_branch(w_cond)) begin
          w_accept = 1'b1;
          w_wr_en  = 1'b1;
          if (w_actual) begin
            w_wr_data = (w_rd_data == CNT_ST) ? CNT_ST : w_rd_data + 2'd1;
          end else begin
            w_wr_data = (w_rd_data == CNT_SNT) ? CNT_SNT : w_rd_data - 2'd1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    // Anything presented on a reset edge is dropped.
    if (!reset_n) begin
      w_accept = 1'b0;
      w_wr_en  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_target  <= '0;
      actual_taken <= 1'b0;
      mispredict   <= 1'b0;
      branch_count <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      pred_valid <= w_accept;
      if (w_accept) begin
        pred_taken   <= w_rd_data[1];
        pred_target  <= latched_branch[10:0];
        actual_taken <= w_actual;
        mispredict   <= w_rd_data[1] ^ w_actual;
        if (branch_count != CNT_MAX) branch_count <= branch_count + CNT_ONE;
        if (w_rd_data[1] == w_actual) begin
          if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_ONE;
        end else begin
          if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_core.sv
// ------------------------------------------------------------------
// tb_branch_predictor_core: scoreboard bench for branch_predictor_core.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor_core;

  localparam int CW = 4;

  logic          clock;
  logic          reset_n;
  logic [13:0]   latched_branch;
  logic [10:0]   latched_branch_addr;
  logic [15:0]   latched_W;
  logic          latched_CY;
  logic          latched_exec_done;
  logic          ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [10:0]   pred_target;
  logic          actual_taken;
  logic          mispredict;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  branch_predictor_core #(
    .INDEX_BITS (6),
    .INIT_STATE (2'b01),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .latched_branch      (latched_branch),
    .latched_branch_addr (latched_branch_addr),
    .latched_W           (latched_W),
    .latched_CY          (latched_CY),
    .latched_exec_done   (latched_exec_done),
    .ready               (ready),
    .pred_valid          (pred_valid),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .actual_taken        (actual_taken),
    .mispredict          (mispredict),
    .branch_count        (branch_count),
    .hit_count           (hit_count),
    .miss_count          (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        pt;
    logic        at;
    logic        mp;
    logic [10:0] tg;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] bht_m [64];
  int         b_m, h_m, m_m;
  logic       model_ready;
  int         n_total, n_pass;

  function automatic logic model_taken(input logic [2:0] c, input logic [15:0] w, input logic cy);
    case (c)
      3'b001:  return 1'b1;
      3'b010:  return w == 16'd0;
      3'b011:  return w != 16'd0;
      3'b100:  return cy == 1'b1;
      3'b101:  return cy == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    b_m = 0; h_m = 0; m_m = 0;
    model_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic sat_inc(inout int v);
    if (v < (2**CW) - 1) v = v + 1;
  endtask

  // Advance one edge and compare against the scoreboard head.
  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (pred_valid !== 1'b1 || pred_taken !== e.pt || actual_taken !== e.at ||
          mispredict !== e.mp || pred_target !== e.tg)
        $display("FAIL pred: got v=%b pt=%b at=%b mp=%b tg=%h, need v=1 pt=%b at=%b mp=%b tg=%h",
                 pred_valid, pred_taken, actual_taken, mispredict, pred_target,
                 e.pt, e.at, e.mp, e.tg);
      else n_pass++;
    end else begin
      if (pred_valid !== 1'b0) $display("FAIL no_pred: got pred_valid=%b, need 0", pred_valid);
      else n_pass++;
    end
    n_total++;
    if (branch_count !== CW'(b_m) || hit_count !== CW'(h_m) || miss_count !== CW'(m_m))
      $display("FAIL stats: got %0d/%0d/%0d, need %0d/%0d/%0d",
               branch_count, hit_count, miss_count, b_m, h_m, m_m);
    else n_pass++;
  endtask

  task automatic drive(input logic [2:0] c, input logic [10:0] addr, input logic [15:0] w,
                       input logic cy, input logic ed);
    exp_t       e;
    logic [1:0] cnt;
    logic       t;
    logic [10:0] tg;
    tg = addr ^ 11'h2A5;
    latched_branch      = {c, tg};
    latched_branch_addr = addr;
    latched_W           = w;
    latched_CY          = cy;
    latched_exec_done   = ed;
    if (model_ready && ed && c >= 3'b001 && c <= 3'b101) begin
      cnt  = bht_m[addr[5:0]];
      t    = model_taken(c, w, cy);
      e.pt = cnt[1];
      e.at = t;
      e.mp = cnt[1] ^ t;
      e.tg = tg;
      exp_q.push_back(e);
      if (t && cnt != 2'b11) bht_m[addr[5:0]] = cnt + 2'd1;
      if (!t && cnt != 2'b00) bht_m[addr[5:0]] = cnt - 2'd1;
      sat_inc(b_m);
      if (e.mp) sat_inc(m_m); else sat_inc(h_m);
    end
    step();
  endtask

  task automatic idle();
    latched_exec_done = 1'b0;
    latched_branch    = '0;
  endtask

  // Counts edges with reset_n=1 until ready rises; expects exactly 64.
  task automatic wait_ready(input logic offer_branch);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      if (offer_branch && n == 9) begin
        latched_branch = {3'b010, 11'h005}; latched_branch_addr = 11'h005;
        latched_W = 16'h0; latched_exec_done = 1'b1;
      end
      @(posedge clock);
      #1;
      n++;
      if (n == 10) idle();
      if (offer_branch && n == 11) begin
        n_total++;
        if (pred_valid !== 1'b0 || branch_count !== '0)
          $display("FAIL clear_ignore: got pred_valid=%b branches=%0d, need 0/0",
                   pred_valid, branch_count);
        else n_pass++;
      end
    end
    n_total++;
    if (n != 64) $display("FAIL ready_timing: ready after %0d edges, need 64", n);
    else n_pass++;
    model_ready = 1'b1;
  endtask

  task automatic check_zero_outputs(input string nm);
    n_total++;
    if (ready !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_target !== '0 ||
        actual_taken !== 1'b0 || mispredict !== 1'b0 || branch_count !== '0 ||
        hit_count !== '0 || miss_count !== '0)
      $display("FAIL %s: got rdy=%b v=%b pt=%b tg=%h at=%b mp=%b cnt=%0d/%0d/%0d, need all 0",
               nm, ready, pred_valid, pred_taken, pred_target, actual_taken, mispredict,
               branch_count, hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    idle();
    latched_branch_addr = '0; latched_W = '0; latched_CY = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero_outputs("reset_state");
    reset_n = 1'b1;
    wait_ready(1'b1);
  endtask

  task automatic test_back_to_back();
    drive(3'b010, 11'h005, 16'h0000, 1'b0, 1'b1);
    n_total++;
    if (pred_taken !== 1'b0 || actual_taken !== 1'b1 || mispredict !== 1'b1)
      $display("FAIL jz_first: got pt=%b at=%b mp=%b, need 0 1 1", pred_taken, actual_taken, mispredict);
    else n_pass++;
    drive(3'b010, 11'h005, 16'h0000, 1'b0, 1'b1);
    n_total++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b0)
      $display("FAIL jz_bypass: got pt=%b mp=%b, need 1 0", pred_taken, mispredict);
    else n_pass++;
    idle();
    n_total++;
    if (branch_count !== 4'd2 || hit_count !== 4'd1 || miss_count !== 4'd1)
      $display("FAIL jz_stats: got %0d/%0d/%0d, need 2/1/1", branch_count, hit_count, miss_count);
    else n_pass++;
  endtask

  task automatic test_aliasing();
    drive(3'b100, 11'h045, 16'h0000, 1'b1, 1'b1);
    drive(3'b011, 11'h005, 16'h1234, 1'b0, 1'b1);
    n_total++;
    if (pred_taken !== 1'b1 || actual_taken !== 1'b1 || mispredict !== 1'b0)
      $display("FAIL alias: got pt=%b at=%b mp=%b, need 1 1 0", pred_taken, actual_taken, mispredict);
    else n_pass++;
    idle();
    step();
  endtask

  task automatic test_counter_saturation();
    for (int i = 0; i < 5; i++) drive(3'b101, 11'h010, 16'h0000, 1'b1, 1'b1);
    drive(3'b101, 11'h010, 16'h0000, 1'b0, 1'b1);
    n_total++;
    if (pred_taken !== 1'b0 || mispredict !== 1'b1)
      $display("FAIL jnc_sat: got pt=%b mp=%b, need 0 1", pred_taken, mispredict);
    else n_pass++;
    idle();
  endtask

  task automatic test_filter();
    drive(3'b000, 11'h005, 16'h0000, 1'b0, 1'b1);
    drive(3'b110, 11'h005, 16'h0000, 1'b0, 1'b1);
    drive(3'b111, 11'h005, 16'h0000, 1'b0, 1'b1);
    drive(3'b010, 11'h005, 16'h0000, 1'b0, 1'b0);
    idle();
    step();
  endtask

  task automatic test_stats_and_reset();
    for (int i = 0; i < 20; i++) drive(3'b001, 11'h000, 16'h0000, 1'b0, 1'b1);
    n_total++;
    if (branch_count !== 4'd15)
      $display("FAIL stat_sat: got branch_count=%0d, need 15", branch_count);
    else n_pass++;
    // Branch offered on the reset edge must vanish.
    latched_branch = {3'b001, 11'h000}; latched_branch_addr = 11'h000;
    latched_exec_done = 1'b1;
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle();
    check_zero_outputs("mid_reset");
    wait_ready(1'b0);
    drive(3'b001, 11'h000, 16'h0000, 1'b0, 1'b1);
    n_total++;
    if (pred_taken !== 1'b0 || actual_taken !== 1'b1 || branch_count !== 4'd1)
      $display("FAIL wnt_after_reset: got pt=%b at=%b br=%0d, need 0 1 1",
               pred_taken, actual_taken, branch_count);
    else n_pass++;
    idle();
    step();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_back_to_back();
    test_aliasing();
    test_counter_saturation();
    test_filter();
    test_stats_and_reset();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d expected results never seen, need 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
